fetch_queue: RTL and testbench

Instruction fetch queue between the memory arbiter and the decode stage. Issues line-aligned 64-byte fetch requests starting at the program entry point and stores returned lines in a 128-byte circular byte buffer. Presents a 15-byte, wrap-aware decode window plus its RIP to the decoder, and retires however many bytes the decoder consumes each cycle. Supports a redirect that flushes the queue and discards any fetch still in flight.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_window_rotate.sv | 12 +
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: shared constants, FSM state type and line-address helper for the fetch queue.
package fetch_pkg;
   localparam int LINE_BYTES = 64;
   localparam int BUF_BYTES  = 128;
   localparam int WIN_BYTES  = 15;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

   function automatic logic [63:0] line_base(input logic [63:0] a);
      return {a[63:6], 6'b0};
   endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: arbiter line request/response, redirect and decode-side window signals.
interface fetch_queue_if;
   import fetch_pkg::*;
   logic                    redirect_valid;
   logic [63:0]             redirect_rip;
   logic                    line_req_valid;
   logic [63:0]             line_req_addr;
   logic                    line_req_ready;
   logic                    line_resp_valid;
   logic [LINE_BYTES*8-1:0] line_resp_data;
   logic [WIN_BYTES*8-1:0]  dec_window;
   logic                    dec_valid;
   logic [7:0]              dec_avail;
   logic [63:0]             dec_rip;
   logic [3:0]              dec_consume;

   modport master (
      input  redirect_valid, redirect_rip, line_req_ready, line_resp_valid, line_resp_data, dec_consume,
      output line_req_valid, line_req_addr, dec_window, dec_valid, dec_avail, dec_rip
   );
   modport slave (
      output redirect_valid, redirect_rip, line_req_ready, line_resp_valid, line_resp_data, dec_consume,
      input  line_req_valid, line_req_addr, dec_window, dec_valid, dec_avail, dec_rip
   );
endinterface

// File: rtl/fetch_window_rotate.sv
// fetch_window_rotate: pulls WIN_BYTES consecutive bytes from the ring starting at head, wrapping at the end.
module fetch_window_rotate
   import fetch_pkg::*;
(
   input  logic [BUF_BYTES-1:0][7:0] ring,
   input  logic [6:0]                head,
   output logic [WIN_BYTES*8-1:0]    window
);
   for (genvar j = 0; j < WIN_BYTES; j++) begin : g_byte
      assign window[WIN_BYTES*8-1-8*j -: 8] = ring[head + 7'(j)];
   end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetches 64-byte lines into a 128-byte ring and presents a 15-byte decode window with its RIP.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] entry,
   fetch_queue_if.master bus
);
   fetch_state_t              state;
   logic [BUF_BYTES-1:0][7:0] ring;
   logic [6:0]                head, tail;
   logic [7:0]                count, in_n, out_n;
   logic [63:0]               fetch_addr;
   logic [5:0]                skip;
   logic                      take, eat;

   assign take = state == WAIT && bus.line_resp_valid && !bus.redirect_valid;
   assign eat = {4'b0, bus.dec_consume} <= count && !bus.redirect_valid;
   assign in_n = take ? 8'(LINE_BYTES) - 8'(skip) : 8'd0;
   assign out_n = eat ? 8'(bus.dec_consume) : 8'd0;
   assign bus.dec_avail = count;
   assign bus.dec_valid = count >= 8'(WIN_BYTES);

   fetch_window_rotate u_rot (.ring(ring), .head(head), .window(bus.dec_window));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ring <= '0;
         head <= '0;
         tail <= '0;
         count <= '0;
         fetch_addr <= line_base(entry);
         skip <= entry[5:0];
         bus.dec_rip <= entry;
         bus.line_req_valid <= 1'b0;
         bus.line_req_addr <= line_base(entry);
      end else begin
         for (int k = 0; k < LINE_BYTES; k++)
            if (take && k >= int'(skip))
               ring[tail + 7'(k) - 7'(skip)] <= bus.line_resp_data[LINE_BYTES*8-1-8*k -: 8];
         head <= bus.redirect_valid ? '0 : head + out_n[6:0];
         tail <= bus.redirect_valid ? '0 : tail + in_n[6:0];
         count <= bus.redirect_valid ? '0 : count + in_n - out_n;
         bus.dec_rip <= bus.redirect_valid ? bus.redirect_rip : bus.dec_rip + 64'(out_n);
         if (bus.redirect_valid) begin
            fetch_addr <= line_base(bus.redirect_rip);
            skip <= bus.redirect_rip[5:0];
         end else if (take) begin
            fetch_addr <= fetch_addr + 64'(LINE_BYTES);
            skip <= '0;
         end
         // A redirected request that is already visible stays up; DROP completes its handshake, then eats its line.
         case (state)
            IDLE: if (!bus.redirect_valid && count <= 8'(BUF_BYTES - LINE_BYTES)) state <= REQ;
            REQ:
               if (!bus.line_req_valid) begin
                  if (!bus.redirect_valid) begin
                     bus.line_req_valid <= 1'b1;
                     bus.line_req_addr <= fetch_addr;
                  end
               end else if (bus.line_req_ready) begin
                  bus.line_req_valid <= 1'b0;
                  state <= bus.redirect_valid ? DROP : WAIT;
               end else if (bus.redirect_valid) state <= DROP;
            WAIT:
               if (bus.line_resp_valid) state <= IDLE;
               else if (bus.redirect_valid) state <= DROP;
            DROP:
               if (bus.line_req_valid) begin
                  if (bus.line_req_ready) bus.line_req_valid <= 1'b0;
               end else if (bus.line_resp_valid) state <= IDLE;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (reset || bus.redirect_valid) {4'b0, bus.dec_consume} <= count)
      else $fatal(1, "dec_consume exceeds queued bytes");
   assert property (@(posedge clk) disable iff (reset || bus.redirect_valid)
      {1'b0, count} + {1'b0, in_n} - {1'b0, out_n} <= 9'(BUF_BYTES))
      else $fatal(1, "fetch queue overflow");
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic checked against a byte-queue reference model.
module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] entry = '0;
   int          n_vec = 0, n_bad = 0;

   fetch_queue_if bus ();
   fetch_queue dut (.clk(clk), .reset(reset), .entry(entry), .bus(bus));

   always #5 clk = ~clk;

   logic [7:0]  q[$];
   logic [63:0] m_rip, m_fetch, held, acc;
   logic [5:0]  m_skip;
   bit          req_live, outst, stale;
   int          cd, resp_delay;

   function automatic logic [7:0] mem(input logic [63:0] a);
      return a[7:0] + a[19:12];
   endfunction

   function automatic logic [511:0] line_data(input logic [63:0] base);
      logic [511:0] d;
      for (int k = 0; k < 64; k++) d[511-8*k -: 8] = mem(base + 64'(k));
      return d;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic compare();
      int sz = q.size();
      logic [119:0] ew = '0, mk = '0;
      for (int j = 0; j < 15; j++)
         if (j < sz) begin
            ew[119-8*j -: 8] = q[j];
            mk[119-8*j -: 8] = 8'hFF;
         end
      chk("avail", bus.dec_avail, sz);
      chk("rip", bus.dec_rip, m_rip);
      chk("dvalid", bus.dec_valid, sz >= 15);
      chk("window", bus.dec_window & mk, ew);
      if (req_live) chk("req_hold", {bus.line_req_valid, bus.line_req_addr}, {1'b1, held});
      else if (bus.line_req_valid) begin
         chk("req_single", outst, 0);
         chk("req_addr", bus.line_req_addr, m_fetch);
         req_live = 1;
         held = m_fetch;
         stale = 0;
      end
   endtask

   task automatic tick();
      bit rv, rdy, rsp, vp, ok;
      logic [63:0] rr;
      int n;
      if (outst && cd != 0) begin
         cd--;
         if (cd == 0) begin
            bus.line_resp_valid = 1'b1;
            bus.line_resp_data = line_data(acc);
         end
      end
      rv = bus.redirect_valid; rr = bus.redirect_rip; rdy = bus.line_req_ready;
      rsp = bus.line_resp_valid; n = bus.dec_consume; vp = bus.line_req_valid;
      @(posedge clk);
      #1;
      ok = n <= q.size();
      if (rsp && outst) begin
         if (!stale && !rv) begin
            for (int k = m_skip; k < 64; k++) q.push_back(mem(acc + 64'(k)));
            m_fetch += 64;
            m_skip = 0;
         end
         outst = 0;
         stale = 0;
      end
      if (vp && rdy) begin
         outst = 1;
         req_live = 0;
         acc = held;
         cd = resp_delay != 0 ? resp_delay : $urandom_range(1, 4);
      end
      if (rv) begin
         if (req_live || outst) stale = 1;
         q.delete();
         m_rip = rr;
         m_fetch = {rr[63:6], 6'b0};
         m_skip = rr[5:0];
      end else if (ok) begin
         repeat (n) void'(q.pop_front());
         m_rip += 64'(n);
      end
      bus.redirect_valid = 1'b0;
      bus.dec_consume = '0;
      bus.line_resp_valid = 1'b0;
      compare();
   endtask

   task automatic do_reset(input logic [63:0] e);
      reset = 1'b1; entry = e;
      bus.line_req_ready = 1'b0; bus.redirect_valid = 1'b0; bus.dec_consume = '0; bus.line_resp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      q.delete();
      m_rip = e; m_fetch = {e[63:6], 6'b0}; m_skip = e[5:0];
      req_live = 0; outst = 0; stale = 0; cd = 0;
      chk("rst_reqv", bus.line_req_valid, 0);
      chk("rst_addr", bus.line_req_addr, {e[63:6], 6'b0});
      chk("rst_window", bus.dec_window, 0);
      chk("rst_avail", bus.dec_avail, 0);
      chk("rst_dvalid", bus.dec_valid, 0);
      chk("rst_rip", bus.dec_rip, e);
      reset = 1'b0;
   endtask

   task automatic wait_req(input int budget);
      int i = 0;
      while (!bus.line_req_valid && i < budget) begin tick(); i++; end
      chk("req_wait", bus.line_req_valid, 1);
   endtask

   task automatic wait_avail(input int v, input int budget);
      int i = 0;
      while (int'(bus.dec_avail) != v && i < budget) begin tick(); i++; end
      chk("avail_wait", bus.dec_avail, v);
   endtask

   initial begin
      bus.redirect_valid = 1'b0; bus.redirect_rip = '0; bus.line_req_ready = 1'b0;
      bus.line_resp_valid = 1'b0; bus.line_resp_data = '0; bus.dec_consume = '0;
      resp_delay = 1;
      do_reset(64'h400004);
      tick(); chk("rise_t1", bus.line_req_valid, 0);
      tick(); chk("rise_t2", bus.line_req_valid, 1);
      chk("t1_addr", bus.line_req_addr, 64'h400000);
      bus.line_req_ready = 1'b1; tick(); bus.line_req_ready = 1'b0; tick();
      chk("t1_avail", bus.dec_avail, 60);
      chk("t1_rip", bus.dec_rip, 64'h400004);
      chk("t1_win_first", bus.dec_window[119:112], 8'h04);
      chk("t1_win_last", bus.dec_window[7:0], 8'h12);
      bus.line_req_ready = 1'b1; wait_avail(124, 20); bus.line_req_ready = 1'b0;
      repeat (9) begin bus.dec_consume = 4'd7; tick(); end
      chk("t2_rip", bus.dec_rip, 64'h400043);
      chk("t2_avail", bus.dec_avail, 61);
      bus.line_req_ready = 1'b1; wait_avail(125, 20); bus.line_req_ready = 1'b0;
      while (q.size() > 65) begin
         bus.dec_consume = 4'((q.size() - 65) > 15 ? 15 : q.size() - 65);
         tick();
      end
      repeat (4) begin tick(); chk("hold65_req", bus.line_req_valid, 0); end
      bus.dec_consume = 4'd1;
      tick(); chk("c64_t0", bus.line_req_valid, 0);
      tick(); chk("c64_t1", bus.line_req_valid, 0);
      tick(); chk("c64_t2", bus.line_req_valid, 1);
      chk("c64_addr", bus.line_req_addr, 64'h4000C0);
      resp_delay = 3;
      bus.line_req_ready = 1'b1; tick(); bus.line_req_ready = 1'b0;
      bus.redirect_valid = 1'b1; bus.redirect_rip = 64'h500010; tick();
      tick(); tick();
      chk("drop_avail", bus.dec_avail, 0);
      wait_req(10);
      chk("redir_addr", bus.line_req_addr, 64'h500000);
      resp_delay = 1;
      bus.line_req_ready = 1'b1; tick(); bus.line_req_ready = 1'b0; tick();
      chk("redir_avail", bus.dec_avail, 48);
      wait_req(10);
      chk("stall_addr0", bus.line_req_addr, 64'h500040);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin bus.redirect_valid = 1'b1; bus.redirect_rip = 64'h600020; end
         tick();
         chk("stall_v", bus.line_req_valid, 1);
         chk("stall_a", bus.line_req_addr, 64'h500040);
      end
      bus.line_req_ready = 1'b1; tick(); bus.line_req_ready = 1'b0; tick();
      chk("stall_drop", bus.dec_avail, 0);
      wait_req(10);
      chk("stall_new", bus.line_req_addr, 64'h600000);
      bus.line_req_ready = 1'b1; tick(); bus.line_req_ready = 1'b0; tick();
      chk("skip32", bus.dec_avail, 32);
      bus.dec_consume = 4'd12; tick();
      wait_req(10);
      bus.line_req_ready = 1'b1; tick(); bus.line_req_ready = 1'b0;
      bus.dec_consume = 4'd15; tick();
      chk("resp_and_consume", bus.dec_avail, 69);
      resp_delay = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset({$urandom, $urandom});
            bus.line_resp_valid = 1'b1; bus.line_resp_data = {16{$urandom}};
            tick();
            chk("stray_avail", bus.dec_avail, 0);
         end
         bus.line_req_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 59) == 0) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_rip = {$urandom, $urandom};
         end else bus.dec_consume = 4'($urandom_range(0, q.size() < 15 ? q.size() : 15));
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
